// File: rtl/matrix_frame_buffer.sv
// Double-buffered 3-bit-per-pixel frame store: game logic writes/clears the back bank,
// the scan engine streams upper/lower row pairs from the front bank to the panel driver.
module matrix_frame_buffer #(
    parameter int COLS = 64,
    parameter int ROWS = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      wr_valid,
    output logic                      wr_ready,
    input  logic [$clog2(COLS)-1:0]   wr_x,
    input  logic [$clog2(ROWS)-1:0]   wr_y,
    input  logic [2:0]                wr_rgb,
    input  logic                      clr_req,
    input  logic                      swap_req,
    output logic                      busy,
    output logic                      swap_done,
    input  logic                      scan_start,
    input  logic [$clog2(ROWS)-2:0]   scan_row,
    output logic                      R0in,
    output logic                      G0in,
    output logic                      B0in,
    output logic                      R1in,
    output logic                      G1in,
    output logic                      B1in
);

    localparam int CW = $clog2(COLS);
    localparam int YW = $clog2(ROWS);
    localparam int RW = YW - 1;
    localparam int WW = RW + CW;
    localparam int AW = WW + 1;

    localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
    localparam logic [WW-1:0] CLR_LAST = WW'(ROWS / 2 * COLS - 1);

    localparam logic [1:0] W_IDLE     = 2'd0;
    localparam logic [1:0] W_CLEAR    = 2'd1;
    localparam logic [1:0] W_SWAPWAIT = 2'd2;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    // Upper-half and lower-half rows live in separate arrays sharing one address,
    // so a clear word or a scan read covers a whole row pair in one access.
    logic [2:0] mem_hi [2**AW];
    logic [2:0] mem_lo [2**AW];

    logic [1:0]    wstate;
    logic          front;
    logic [WW-1:0] clr_addr;

    logic          we_hi;
    logic          we_lo;
    logic [AW-1:0] wr_addr;
    logic [2:0]    wr_data;

    logic [0:0]    sstate;
    logic [RW-1:0] row;
    logic [CW-1:0] col;
    logic [AW-1:0] rd_addr;

    logic          vld_p0;
    logic [2:0]    hi_p0;
    logic [2:0]    lo_p0;

    assign wr_ready  = (wstate == W_IDLE);
    assign busy      = (wstate != W_IDLE);
    assign swap_done = (wstate == W_SWAPWAIT) && scan_start && (scan_row == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wstate   <= W_IDLE;
            front    <= 1'b0;
            clr_addr <= '0;
        end else begin
            case (wstate)
                W_IDLE: begin
                    if (clr_req) begin
                        wstate   <= W_CLEAR;
                        clr_addr <= '0;
                    end else if (swap_req) begin
                        wstate <= W_SWAPWAIT;
                    end
                end
                W_CLEAR: begin
                    clr_addr <= clr_addr + 1'b1;
                    if (clr_addr == CLR_LAST) wstate <= W_IDLE;
                end
                W_SWAPWAIT: begin
                    if (swap_done) begin
                        front  <= ~front;
                        wstate <= W_IDLE;
                    end
                end
                default: wstate <= W_IDLE;
            endcase
        end
    end

    always_comb begin
        we_hi   = 1'b0;
        we_lo   = 1'b0;
        wr_addr = {~front, wr_y[RW-1:0], wr_x};
        wr_data = wr_rgb;
        if (wstate == W_CLEAR) begin
            we_hi   = 1'b1;
            we_lo   = 1'b1;
            wr_addr = {~front, clr_addr};
            wr_data = 3'b000;
        end else if (wstate == W_IDLE && wr_valid) begin
            we_hi = ~wr_y[YW-1];
            we_lo = wr_y[YW-1];
        end
    end

    always_ff @(posedge clk) begin
        if (we_hi) mem_hi[wr_addr] <= wr_data;
        if (we_lo) mem_lo[wr_addr] <= wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sstate <= S_IDLE;
            row    <= '0;
            col    <= '0;
        end else if (scan_start) begin
            sstate <= S_RUN;
            row    <= scan_row;
            col    <= '0;
        end else if (sstate == S_RUN) begin
            if (col == COL_LAST) sstate <= S_IDLE;
            else                 col    <= col + 1'b1;
        end
    end

    assign rd_addr = {front, row, col};

    // ---- stage p0: front-bank read, valid gates the panel outputs ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) vld_p0 <= 1'b0;
        else        vld_p0 <= (sstate == S_RUN);
    end

    always_ff @(posedge clk) begin
        hi_p0 <= mem_hi[rd_addr];
        lo_p0 <= mem_lo[rd_addr];
    end

    assign {R0in, G0in, B0in} = vld_p0 ? hi_p0 : 3'b000;
    assign {R1in, G1in, B1in} = vld_p0 ? lo_p0 : 3'b000;

endmodule

// File: tb/tb_matrix_frame_buffer.sv
// Directed bench for matrix_frame_buffer: clear, write, swap timing, restart and reset behaviour.
module tb_matrix_frame_buffer;

    localparam int COLS = 64;
    localparam int ROWS = 32;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_valid = 1'b0;
    logic       wr_ready;
    logic [5:0] wr_x = '0;
    logic [4:0] wr_y = '0;
    logic [2:0] wr_rgb = '0;
    logic       clr_req = 1'b0;
    logic       swap_req = 1'b0;
    logic       busy;
    logic       swap_done;
    logic       scan_start = 1'b0;
    logic [3:0] scan_row = '0;
    logic       R0in, G0in, B0in, R1in, G1in, B1in;

    logic [2:0] rgb_hi;
    logic [2:0] rgb_lo;
    assign rgb_hi = {R0in, G0in, B0in};
    assign rgb_lo = {R1in, G1in, B1in};

    int pass_cnt = 0;
    int total_cnt = 0;

    logic [2:0] cap_hi [COLS];
    logic [2:0] cap_lo [COLS];
    logic [5:0] cap_pre;
    logic [5:0] cap_post;
    logic       cap_sd;

    matrix_frame_buffer #(.COLS(COLS), .ROWS(ROWS)) dut (
        .clk(clk), .rst_n(rst_n),
        .wr_valid(wr_valid), .wr_ready(wr_ready),
        .wr_x(wr_x), .wr_y(wr_y), .wr_rgb(wr_rgb),
        .clr_req(clr_req), .swap_req(swap_req),
        .busy(busy), .swap_done(swap_done),
        .scan_start(scan_start), .scan_row(scan_row),
        .R0in(R0in), .G0in(G0in), .B0in(B0in),
        .R1in(R1in), .G1in(G1in), .B1in(B1in)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wr_pix(input int x, input int y, input logic [2:0] rgb);
        wr_x = 6'(x);
        wr_y = 5'(y);
        wr_rgb = rgb;
        wr_valid = 1'b1;
        tick(1);
        wr_valid = 1'b0;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (busy && n < 2000) begin
            tick(1);
            n++;
        end
    endtask

    task automatic do_clear(output int n);
        clr_req = 1'b1;
        tick(1);
        clr_req = 1'b0;
        wait_idle(n);
    endtask

    // Column c of a scan started in cycle t is sampled in cycle t+2+c.
    task automatic scan(input int r);
        scan_row = 4'(r);
        scan_start = 1'b1;
        #1;
        cap_sd = swap_done;
        tick(1);
        scan_start = 1'b0;
        cap_pre = {rgb_hi, rgb_lo};
        tick(1);
        for (int c = 0; c < COLS; c++) begin
            cap_hi[c] = rgb_hi;
            cap_lo[c] = rgb_lo;
            tick(1);
        end
        cap_post = {rgb_hi, rgb_lo};
    endtask

    task automatic request_swap();
        swap_req = 1'b1;
        tick(1);
        swap_req = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(2);
        total_cnt++;
        if (wr_ready !== 1'b1) $display("FAIL reset_wr_ready got %b want 1", wr_ready); else pass_cnt++;
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy); else pass_cnt++;
        total_cnt++;
        if (swap_done !== 1'b0) $display("FAIL reset_swap_done got %b want 0", swap_done); else pass_cnt++;
        total_cnt++;
        if ({rgb_hi, rgb_lo} !== 6'b0) $display("FAIL reset_rgb got %b want 000000", {rgb_hi, rgb_lo}); else pass_cnt++;
        rst_n = 1'b1;
        tick(1);
    endtask

    task automatic test_clear_swap();
        int n;
        int nz;
        do_clear(n);
        total_cnt++;
        if (n !== 1024) $display("FAIL clear1_cycles got %0d want 1024", n); else pass_cnt++;
        request_swap();
        total_cnt++;
        if (busy !== 1'b1) $display("FAIL swap_pending_busy got %b want 1", busy); else pass_cnt++;
        scan(0);
        total_cnt++;
        if (cap_sd !== 1'b1) $display("FAIL swap1_done got %b want 1", cap_sd); else pass_cnt++;
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL swap1_busy got %b want 0", busy); else pass_cnt++;
        do_clear(n);
        total_cnt++;
        if (n !== 1024 || busy !== 1'b0) $display("FAIL clear2 got cycles %0d busy %b want 1024 0", n, busy); else pass_cnt++;
        for (int r = 0; r < ROWS / 2; r++) begin
            scan(r);
            nz = 0;
            for (int c = 0; c < COLS; c++) if (cap_hi[c] !== 3'b000 || cap_lo[c] !== 3'b000) nz++;
            if (cap_pre !== 6'b0 || cap_post !== 6'b0) nz++;
            total_cnt++;
            if (nz !== 0) $display("FAIL blank_row%0d got %0d nonzero want 0", r, nz); else pass_cnt++;
        end
    endtask

    task automatic test_pixel_write();
        int nz;
        total_cnt++;
        if (wr_ready !== 1'b1) $display("FAIL idle_wr_ready got %b want 1", wr_ready); else pass_cnt++;
        wr_pix(5, 3, 3'b100);
        wr_pix(5, 19, 3'b011);
        request_swap();
        scan(0);
        total_cnt++;
        if (cap_sd !== 1'b1) $display("FAIL swap2_done got %b want 1", cap_sd); else pass_cnt++;
        scan(3);
        total_cnt++;
        if (cap_hi[5] !== 3'b100) $display("FAIL px_upper got %b want 100", cap_hi[5]); else pass_cnt++;
        total_cnt++;
        if (cap_lo[5] !== 3'b011) $display("FAIL px_lower got %b want 011", cap_lo[5]); else pass_cnt++;
        nz = 0;
        for (int c = 0; c < COLS; c++) if (c != 5 && (cap_hi[c] !== 3'b000 || cap_lo[c] !== 3'b000)) nz++;
        if (cap_post !== 6'b0) nz++;
        total_cnt++;
        if (nz !== 0) $display("FAIL px_others got %0d nonzero want 0", nz); else pass_cnt++;
    endtask

    task automatic test_swap_wait();
        wr_pix(10, 7, 3'b111);
        wr_pix(10, 23, 3'b010);
        wr_pix(20, 0, 3'b110);
        request_swap();
        scan(7);
        total_cnt++;
        if (cap_sd !== 1'b0) $display("FAIL row7_no_swap got %b want 0", cap_sd); else pass_cnt++;
        total_cnt++;
        if (cap_hi[10] !== 3'b000) $display("FAIL row7_old_bank got %b want 000", cap_hi[10]); else pass_cnt++;
        total_cnt++;
        if (busy !== 1'b1) $display("FAIL row7_still_busy got %b want 1", busy); else pass_cnt++;
        scan(0);
        total_cnt++;
        if (cap_sd !== 1'b1) $display("FAIL row0_swap_done got %b want 1", cap_sd); else pass_cnt++;
        total_cnt++;
        if (cap_hi[20] !== 3'b110) $display("FAIL row0_new_bank got %b want 110", cap_hi[20]); else pass_cnt++;
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL row0_busy got %b want 0", busy); else pass_cnt++;
        scan(7);
        total_cnt++;
        if (cap_hi[10] !== 3'b111 || cap_lo[10] !== 3'b010)
            $display("FAIL row7_new got %b/%b want 111/010", cap_hi[10], cap_lo[10]);
        else pass_cnt++;
    endtask

    task automatic test_clear_blocks_write();
        int n;
        int ready_seen;
        int nz;
        n = 0;
        ready_seen = 0;
        wr_x = 6'd0;
        wr_y = 5'd0;
        wr_rgb = 3'b101;
        wr_valid = 1'b1;
        clr_req = 1'b1;
        tick(1);
        clr_req = 1'b0;
        while (busy && n < 2000) begin
            if (wr_ready) ready_seen++;
            n++;
            tick(1);
        end
        wr_valid = 1'b0;
        total_cnt++;
        if (n !== 1024) $display("FAIL clear_hold_cycles got %0d want 1024", n); else pass_cnt++;
        total_cnt++;
        if (ready_seen !== 0) $display("FAIL clear_wr_ready got %0d ready cycles want 0", ready_seen); else pass_cnt++;
        request_swap();
        scan(0);
        total_cnt++;
        if (cap_sd !== 1'b1) $display("FAIL swap4_done got %b want 1", cap_sd); else pass_cnt++;
        nz = 0;
        for (int c = 0; c < COLS; c++) if (cap_hi[c] !== 3'b000 || cap_lo[c] !== 3'b000) nz++;
        total_cnt++;
        if (nz !== 0) $display("FAIL clear_no_write got %0d nonzero want 0", nz); else pass_cnt++;
        scan(3);
        total_cnt++;
        if (cap_hi[5] !== 3'b000 || cap_lo[5] !== 3'b000)
            $display("FAIL clear_wiped got %b/%b want 000/000", cap_hi[5], cap_lo[5]);
        else pass_cnt++;
    endtask

    task automatic test_clr_swap_same();
        int n;
        wr_pix(30, 0, 3'b001);
        request_swap();
        scan(0);
        total_cnt++;
        if (cap_sd !== 1'b1 || cap_hi[30] !== 3'b001)
            $display("FAIL swap5_setup got sd %b px %b want 1 001", cap_sd, cap_hi[30]);
        else pass_cnt++;
        clr_req = 1'b1;
        swap_req = 1'b1;
        tick(1);
        clr_req = 1'b0;
        swap_req = 1'b0;
        wait_idle(n);
        total_cnt++;
        if (n !== 1024) $display("FAIL both_clear_cycles got %0d want 1024", n); else pass_cnt++;
        scan(0);
        total_cnt++;
        if (cap_sd !== 1'b0) $display("FAIL both_swap_dropped got %b want 0", cap_sd); else pass_cnt++;
        total_cnt++;
        if (cap_hi[30] !== 3'b001 || cap_hi[20] !== 3'b110)
            $display("FAIL both_front_kept got %b/%b want 001/110", cap_hi[30], cap_hi[20]);
        else pass_cnt++;
        total_cnt++;
        if (busy !== 1'b0) $display("FAIL both_busy got %b want 0", busy); else pass_cnt++;
    endtask

    task automatic test_scan_restart();
        wr_pix(0, 9, 3'b111);
        wr_pix(1, 25, 3'b110);
        wr_pix(5, 9, 3'b010);
        wr_pix(12, 2, 3'b011);
        request_swap();
        scan(0);
        total_cnt++;
        if (cap_sd !== 1'b1) $display("FAIL swap6_done got %b want 1", cap_sd); else pass_cnt++;
        scan_row = 4'd2;
        scan_start = 1'b1;
        tick(1);
        scan_start = 1'b0;
        tick(10);
        // column 10 of row 2 is being read in this cycle
        scan_row = 4'd9;
        scan_start = 1'b1;
        tick(1);
        scan_start = 1'b0;
        tick(1);
        total_cnt++;
        if (rgb_hi !== 3'b111 || rgb_lo !== 3'b000)
            $display("FAIL restart_col0 got %b/%b want 111/000", rgb_hi, rgb_lo);
        else pass_cnt++;
        tick(1);
        total_cnt++;
        if (rgb_hi !== 3'b000 || rgb_lo !== 3'b110)
            $display("FAIL restart_col1 got %b/%b want 000/110", rgb_hi, rgb_lo);
        else pass_cnt++;
        tick(4);
        total_cnt++;
        if (rgb_hi !== 3'b010) $display("FAIL restart_col5 got %b want 010", rgb_hi); else pass_cnt++;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({rgb_hi, rgb_lo} !== 6'b0) $display("FAIL midscan_reset_rgb got %b want 000000", {rgb_hi, rgb_lo}); else pass_cnt++;
        total_cnt++;
        if (wr_ready !== 1'b1 || busy !== 1'b0)
            $display("FAIL midscan_reset_ctrl got ready %b busy %b want 1 0", wr_ready, busy);
        else pass_cnt++;
        tick(2);
        total_cnt++;
        if ({rgb_hi, rgb_lo} !== 6'b0) $display("FAIL reset_hold_rgb got %b want 000000", {rgb_hi, rgb_lo}); else pass_cnt++;
        rst_n = 1'b1;
        tick(1);
    endtask

    initial begin
        test_reset();
        test_clear_swap();
        test_pixel_write();
        test_swap_wait();
        test_clear_blocks_write();
        test_clr_swap_same();
        test_scan_restart();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
